// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported, synchronous-read data memory
// between the load/store path (port 0) and a secondary master (port 1).
// At most one access is granted per cycle: round-robin, with an optional
// bounded lock so that one master can burst. Read data returns one cycle
// after the access and is qualified by a per-port valid strobe.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Wide enough to hold 0..MAX_LOCK.
    localparam int CNT_W = (MAX_LOCK < 2) ? 1 : $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    // Arbitration state.
    logic             last_grant_q, last_grant_d;
    logic             lock_valid_q, lock_valid_d;
    logic             lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0] lock_cnt_q,   lock_cnt_d;
    logic [1:0]       rvalid_q,     rvalid_d;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       owner_req;
    logic       lock_hold;
    logic       grant_port;
    logic       grant_lock;

    assign req       = {m1_req, m0_req};
    assign owner_req = lock_owner_q ? m1_req : m0_req;
    // A lock only survives while its owner keeps requesting; otherwise it
    // is dropped in the same cycle and round-robin takes over.
    assign lock_hold = lock_valid_q & owner_req;

    // Grant selection: live lock first, then round-robin, then sole requester.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        gnt = 2'b00;
        if (reset) begin
            gnt = 2'b00;
        end else if (lock_hold) begin
            gnt[lock_owner_q] = 1'b1;
        end else if (req == 2'b11) begin
            gnt[~last_grant_q] = 1'b1;
        end else if (m0_req) begin
            gnt[0] = 1'b1;
        end else if (m1_req) begin
            gnt[1] = 1'b1;
        end
    end

    assign m0_gnt     = gnt[0];
    assign m1_gnt     = gnt[1];
    assign grant_port = gnt[1];
    assign grant_lock = grant_port ? m1_lock : m0_lock;

    // Memory port mux: the granted master drives the memory; idle keeps we low.
    always_comb begin
        mem_en    = |gnt;
        mem_we    = 1'b0;
        mem_addr  = grant_port ? m1_addr  : m0_addr;
        mem_wdata = grant_port ? m1_wdata : m0_wdata;
        if (gnt[1]) begin
            mem_we = m1_we;
        end else if (gnt[0]) begin
            mem_we = m0_we;
        end
    end

    // Next-state for round-robin pointer, lock tracking and read strobes.
    always_comb begin
        last_grant_d = last_grant_q;
        lock_valid_d = lock_hold;
        lock_owner_d = lock_owner_q;
        lock_cnt_d   = lock_hold ? lock_cnt_q : '0;
        rvalid_d     = {gnt[1] & ~m1_we, gnt[0] & ~m0_we};

        if (mem_en) begin
            last_grant_d = grant_port;
            if (grant_lock) begin
                if (lock_hold) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end else begin
                    lock_valid_d = 1'b1;
                    lock_owner_d = grant_port;
                    lock_cnt_d   = CNT_W'(1);
                end
                // Burst budget exhausted: hand back to round-robin, where
                // last_grant lets the other master win the next contention.
                if (lock_cnt_d == CNT_MAX) begin
                    lock_valid_d = 1'b0;
                    lock_cnt_d   = '0;
                end
            end else begin
                lock_valid_d = 1'b0;
                lock_cnt_d   = '0;
            end
        end
    end

    // State registers; reset makes port 0 win the first contention and
    // drops any read strobe still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            lock_cnt_q   <= '0;
            rvalid_q     <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural model of the
// arbitration rules and a shadow copy of memory.
module tb_dmem_arbiter;

    localparam int MAX_LOCK = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req, we, lk;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];

    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (req[0]),
        .m0_we     (we[0]),
        .m0_lock   (lk[0]),
        .m0_addr   (addr[0]),
        .m0_wdata  (wdata[0]),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (req[1]),
        .m1_we     (we[1]),
        .m1_lock   (lk[1]),
        .m1_addr   (addr[1]),
        .m1_wdata  (wdata[1]),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int i);
        return (i == 4) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i * 32'h111);
    endfunction

    // Synchronous-read memory with 16 words, loaded while reset is held.
    logic [31:0] tb_mem [16];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= init_val(i);
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr[5:2]];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state.
    int          m_last, m_owner, m_cnt;
    bit          m_locked;
    logic [31:0] exp_mem [16];
    int          wait_cnt [2];

    task automatic model_reset();
        m_last   = 1;
        m_locked = 0;
        m_owner  = 0;
        m_cnt    = 0;
        wait_cnt = '{0, 0};
        for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
    endtask

    // One cycle: inputs already applied just after a falling edge. Checks the
    // combinational grant/mux, advances the model, then checks read return.
    task automatic tick(output int g);
        bit          hold;
        bit          nrv [2];
        logic [31:0] nrd;
        int          idx;
        nrv = '{0, 0};
        nrd = '0;
        #1;
        hold = m_locked && req[m_owner];
        if (hold)              g = m_owner;
        else if (req == 2'b11) g = 1 - m_last;
        else if (req[0])       g = 0;
        else if (req[1])       g = 1;
        else                   g = -1;

        check("m0_gnt", 32'(m0_gnt), 32'(g == 0));
        check("m1_gnt", 32'(m1_gnt), 32'(g == 1));
        check("mem_en", 32'(mem_en), 32'(g >= 0));
        if (!hold) m_locked = 0;

        if (g >= 0) begin
            check("mem_we", 32'(mem_we), 32'(we[g]));
            check("mem_addr", mem_addr, addr[g]);
            idx = int'(addr[g][5:2]);
            if (we[g]) begin
                check("mem_wdata", mem_wdata, wdata[g]);
                exp_mem[idx] = wdata[g];
            end else begin
                nrv[g] = 1;
                nrd    = exp_mem[idx];
            end
            check("wait_bound", 32'(wait_cnt[g] <= MAX_LOCK), 32'd1);
            wait_cnt[g] = 0;
            m_last = g;
            if (lk[g]) begin
                if (hold) m_cnt++;
                else begin
                    m_locked = 1;
                    m_owner  = g;
                    m_cnt    = 1;
                end
                if (m_cnt >= MAX_LOCK) begin
                    m_locked = 0;
                    m_cnt    = 0;
                end
            end else begin
                m_locked = 0;
                m_cnt    = 0;
            end
        end else begin
            check("mem_we_idle", 32'(mem_we), 32'd0);
        end
        for (int p = 0; p < 2; p++) if (req[p] && g != p) wait_cnt[p]++;

        @(negedge clk);
        check("m0_rvalid", 32'(m0_rvalid), 32'(nrv[0]));
        check("m1_rvalid", 32'(m1_rvalid), 32'(nrv[1]));
        if (nrv[0]) check("m0_rdata", m0_rdata, nrd);
        if (nrv[1]) check("m1_rdata", m1_rdata, nrd);
    endtask

    task automatic new_txn(int p);
        req[p]   = ($urandom % 4) != 0;
        we[p]    = 1'($urandom % 2);
        lk[p]    = ($urandom % 3) == 0;
        addr[p]  = 32'($urandom_range(0, 15)) << 2;
        wdata[p] = $urandom;
    endtask

    int g;
    int seq [6];

    initial begin
        req = '0; we = '0; lk = '0;
        addr = '{32'h0, 32'h4};
        wdata = '{32'h0, 32'h0};
        model_reset();

        // Reset state, with both masters requesting: nothing may be granted.
        req = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        check("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        check("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Continuous contention without lock alternates, port 0 first.
        for (int i = 0; i < 5; i++) begin
            tick(g);
            check("rr_alt", 32'(g), 32'(i % 2));
        end
        req = 2'b00;
        tick(g);

        // Sole m0 read of 0x10 returns DEADBEEF next cycle.
        req = 2'b01; we[0] = 1'b0; addr[0] = 32'h10;
        tick(g);
        check("rd_gnt", 32'(g), 32'd0);
        check("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);

        // m1 locked write burst against a waiting m0 read.
        seq = '{1, 1, 1, 1, 0, 1};
        req = 2'b11; we = 2'b10; lk = 2'b10;
        addr[0] = 32'h8; addr[1] = 32'h30; wdata[1] = 32'h5555_0000;
        for (int i = 0; i < 6; i++) begin
            tick(g);
            check("lock_seq", 32'(g), 32'(seq[i]));
            if (g == 1) begin
                addr[1]  = addr[1] + 32'h4;
                wdata[1] = wdata[1] + 32'h1;
            end
            if (g == 0) req[0] = 1'b0;
        end
        req = 2'b00; lk = 2'b00;
        tick(g);

        // Locked owner m0 drops its request; m1 gets in immediately.
        req = 2'b01; we = 2'b00; lk = 2'b01; addr[0] = 32'h4;
        tick(g);
        check("lk_own", 32'(g), 32'd0);
        req = 2'b10; lk = 2'b00; addr[1] = 32'h8;
        tick(g);
        check("lk_drop", 32'(g), 32'd1);
        req = 2'b00;
        tick(g);

        // m0 writes 0x1234 to 0x20, m1 reads it back the next cycle.
        req = 2'b01; we = 2'b01; addr[0] = 32'h20; wdata[0] = 32'h1234;
        tick(g);
        req = 2'b10; we = 2'b00; addr[1] = 32'h20;
        tick(g);
        check("wr_rd_rvalid", 32'(m1_rvalid), 32'd1);
        check("wr_rd_data", m1_rdata, 32'h1234);
        check("wr_rd_m0_rvalid", 32'(m0_rvalid), 32'd0);

        // Reset arrives right behind a granted m0 read.
        req = 2'b01; we = 2'b00; addr[0] = 32'h10;
        #1;
        check("mr_gnt", 32'(m0_gnt), 32'd1);
        reset = 1'b1;
        req = 2'b11;
        #1;
        check("mr_m0_gnt", 32'(m0_gnt), 32'd0);
        check("mr_m1_gnt", 32'(m1_gnt), 32'd0);
        check("mr_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        check("mr_rvalid", 32'(m0_rvalid), 32'd0);
        @(negedge clk);
        check("mr_gnt_hold", 32'(m0_gnt | m1_gnt), 32'd0);
        model_reset();
        reset = 1'b0;
        tick(g);
        check("mr_restart", 32'(g), 32'd0);

        // Random traffic: requesters hold their transaction until granted.
        for (int p = 0; p < 2; p++) new_txn(p);
        for (int c = 0; c < 400; c++) begin
            tick(g);
            for (int p = 0; p < 2; p++) if (g == p || !req[p]) new_txn(p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported, synchronous-read data memory between the processor load/store path (port 0) and a secondary master such as a program loader or debug/DMA engine (port 1). It grants at most one access per cycle, round-robin with optional bounded locking for bursts. It drives the memory port and routes the one-cycle-latency read data back to the issuing requester with a per-port valid strobe.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_LOCK, 4, max consecutive locked transfers by one port (≥1)

Ports (clock/reset: **reset reset, asynchronous, active-high; clock clk.**):
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- mN_req  in  1  port N (N=0,1) access request
- mN_we  in  1  1=write, 0=read
- mN_lock  in  1  request to keep ownership after this transfer
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_gnt  out  1  transfer accepted this cycle (combinational)
- mN_rvalid  out  1  read data valid for port N (registered)
- mN_rdata  out  DATA_W  read data (= mem_rdata)
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid cycle after mem_en & !mem_we

## Operation
- A transfer on port N occurs in any cycle where mN_req & mN_gnt. At most one gnt is high per cycle; gnt is never high without its req.
- State: last_grant (1 bit), lock_valid, lock_owner (1 bit), lock_cnt (0..MAX_LOCK), rvalid_q[1:0].
- Grant selection, in priority order:
  - lock_valid and owner requests → grant owner.
  - lock_valid and owner not requesting → lock released immediately (same cycle), fall through to round-robin.
  - Both request → grant port ≠ last_grant.
  - One requests → grant it.
  - None → no grant, mem_en=0.
- Memory mux: mem_en = any gnt; mem_we/addr/wdata copied from granted port; when no grant, mem_we=0 and addr/wdata are don't-care.
- On every transfer: last_grant ← granted port.
- Lock update on transfer by port N:
  - mN_lock=1 and not locked → lock_valid=1, lock_owner=N, lock_cnt=1.
  - Owner transfer with lock=1 → lock_cnt+1.
  - Owner transfer with lock=0 → lock cleared.
  - lock_cnt reaches MAX_LOCK → lock forcibly cleared regardless of mN_lock. The other port then wins the next contended cycle via last_grant.
- Read return: rvalid_q[N] ← transfer on N & !mN_we. mN_rvalid = rvalid_q[N]. Both mN_rdata = mem_rdata; consumers qualify with rvalid.
- Writes produce no response.

## Timing
- Reset values: mN_gnt=0, mN_rvalid=0, mem_en=0, mem_we=0, lock_valid=0, lock_cnt=0, last_grant=1 (port 0 wins first contention).
- While reset is asserted, all gnt and mem_en are forced 0. Reset mid-read drops the pending rvalid.
- Grant latency: 0 cycles. gnt is combinational from req, lock state and last_grant, so a sole requester is granted in its request cycle.
- Read latency: rvalid exactly 1 cycle after the read transfer. Back-to-back reads yield back-to-back rvalid.
- A requester holds req/we/addr/wdata stable until gnt. A waiting port is granted within MAX_LOCK+1 cycles of continuous request.
- MAX_LOCK=1 degenerates to pure round-robin.

## Test plan
- Reset then m0 read of addr 0x10 (memory holds 0xDEADBEEF) → m0_gnt same cycle, m0_rvalid=1 with m0_rdata=0xDEADBEEF next cycle; m1_rvalid stays 0.
- Both ports request continuously with lock=0 → grants alternate 0,1,0,1…; port 0 is granted first after reset.
- m1 holds lock=1 with 6 writes queued while m0 requests (MAX_LOCK=4) → m1 granted 4 cycles, m0 granted 5th cycle, m1 granted 6th.
- Locked owner m0 drops req for one cycle while m1 requests → m1 granted that cycle, lock_valid=0.
- m0 write 0x1234 to 0x20, then m1 read 0x20 next cycle → mem_we=1 then 0, m1_rvalid with 0x1234, no m0_rvalid.
- Assert reset the cycle after a granted m0 read → m0_rvalid stays 0, all gnt=0 during reset, arbitration restarts with port 0 priority.
